dpll_backtrack_ctrl: RTL

- Decision/backtrack controller that sits directly upstream of the formula stack and drives its push/pop interface.
- On each solver decision it checkpoints the current formula onto the stack and records the decision on an internal trail.
- On a conflict it pops checkpoints, restores the formula and issues the flipped decision (chronological DPLL backtracking).
- When no untried branch remains it declares UNSAT.

---
 rtl/dpll_backtrack_ctrl_pkg.sv | 36 +++
 rtl/dpll_backtrack_ctrl_if.sv | 36 +++
 rtl/dpll_backtrack_ctrl_decision_trail.sv | 64 ++++++
 rtl/dpll_backtrack_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dpll_backtrack_ctrl_pkg.sv
// Shared types for the DPLL decision/backtrack controller.
//   formula            : checkpointed solver formula state
//   zero_formula       : idle/reset value of every formula-typed output
//   formula_stack_size : default decision depth (matches formula stack capacity)
//   trail_entry        : one decision on the trail {var_id, val, flipped}
//   bt_state_t         : controller FSM state encoding
package dpll_backtrack_ctrl_pkg;

  localparam int FORMULA_W          = 16;
  localparam int formula_stack_size = 4;
  localparam int TRAIL_VAR_W        = 8;

  typedef logic [FORMULA_W-1:0] formula;

  localparam formula zero_formula = '0;

  // 'var' is a reserved word, hence var_id for the decided variable.
  typedef struct packed {
    logic [TRAIL_VAR_W-1:0] var_id;
    logic                   val;
    logic                   flipped;
  } trail_entry;

  typedef enum logic [3:0] {
    IDLE,
    PUSH,
    BT_CHECK,
    POP,
    WAIT,
    RESTORE,
    DISCARD,
    DONE_UNSAT,
    ERR
  } bt_state_t;

endpackage

// File: rtl/dpll_backtrack_ctrl_if.sv
// Push/pop bus between the backtrack controller and the formula stack.
//   stk_wr_en : push strobe            (controller -> stack)
//   stk_pop   : pop strobe             (controller -> stack)
//   stk_din   : push data              (controller -> stack)
//   stk_full  : stack full             (stack -> controller)
//   stk_empty : stack empty            (stack -> controller)
//   stk_dout  : pop data, valid the cycle after stk_pop (stack -> controller)
interface dpll_backtrack_ctrl_if;
  import dpll_backtrack_ctrl_pkg::*;

  logic   stk_wr_en;
  logic   stk_pop;
  formula stk_din;
  logic   stk_full;
  logic   stk_empty;
  formula stk_dout;

  modport master (
    output stk_wr_en,
    output stk_pop,
    output stk_din,
    input  stk_full,
    input  stk_empty,
    input  stk_dout
  );

  modport slave (
    input  stk_wr_en,
    input  stk_pop,
    input  stk_din,
    output stk_full,
    output stk_empty,
    output stk_dout
  );

endinterface

// File: rtl/dpll_backtrack_ctrl_decision_trail.sv
// Register-array LIFO holding one trail_entry per decision level.
//   clock, reset : clock, asynchronous active-high reset (clears count)
//   push         : append din (ignored when full)
//   pop          : drop top entry (ignored when empty)
//   set_flipped  : mark top entry as already flipped
//   din          : entry to push
//   top          : current top entry (zero when empty)
//   count        : number of entries held, 0..DEPTH
// DEPTH must be at least 2.
module dpll_backtrack_ctrl_decision_trail
  import dpll_backtrack_ctrl_pkg::*;
#(
  parameter  int DEPTH = formula_stack_size,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             set_flipped,
  input  trail_entry       din,
  output trail_entry       top,
  output logic [CNT_W-1:0] count
);

  trail_entry       mem [DEPTH];
  logic             not_full;
  logic             not_empty;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign not_full  = (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign wr_idx    = count[IDX_W-1:0];
  assign top_idx   = IDX_W'(count - CNT_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && not_full) begin
      count <= count + CNT_W'(1);
    end else if (pop && not_empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries above count are never observed.
  always_ff @(posedge clock) begin
    if (push && not_full) begin
      mem[wr_idx] <= din;
    end else if (set_flipped && not_empty) begin
      mem[top_idx].flipped <= 1'b1;
    end
  end

  always_comb begin
    top = '0;
    if (not_empty) begin
      top = mem[top_idx];
    end
  end

endmodule

// File: rtl/dpll_backtrack_ctrl.sv
// Chronological DPLL decision/backtrack controller driving the formula stack.
//   clock, reset    : clock, asynchronous active-high reset (shared with stack)
//   decide          : decision strobe (sampled when ready)
//   dec_var/dec_val : decided variable and polarity
//   cur_formula     : formula checkpointed on decide
//   conflict        : conflict strobe (sampled when ready, beats decide)
//   stk             : formula stack push/pop bus (master side)
//   ready           : idle and accepting decide/conflict
//   restore_valid   : one-cycle pulse, restore_formula/flip_var/flip_val valid
//   level           : current decision depth
//   unsat, error    : sticky terminal flags
//
// state      | meaning
// IDLE       | waiting for decide/conflict
// PUSH       | checkpoint captured formula, push decision on trail
// BT_CHECK   | backtrack: any decision level left?
// POP        | pop checkpoint of top level from formula stack
// WAIT       | stack pop data settles, capture it
// RESTORE    | reload formula, issue flipped decision, re-push checkpoint
// DISCARD    | top decision already flipped, drop the level
// DONE_UNSAT | no untried branch left
// ERR        | overflow or stack/trail mismatch
module dpll_backtrack_ctrl
  import dpll_backtrack_ctrl_pkg::*;
#(
  parameter  int DEPTH = formula_stack_size,
  parameter  int VAR_W = TRAIL_VAR_W,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  decide,
  input  logic [VAR_W-1:0]      dec_var,
  input  logic                  dec_val,
  input  formula                cur_formula,
  input  logic                  conflict,
  dpll_backtrack_ctrl_if.master stk,
  output logic                  ready,
  output logic                  restore_valid,
  output formula                restore_formula,
  output logic [VAR_W-1:0]      flip_var,
  output logic                  flip_val,
  output logic [LVL_W-1:0]      level,
  output logic                  unsat,
  output logic                  error
);

  bt_state_t        state;
  bt_state_t        state_nxt;
  formula           formula_q;
  logic [VAR_W-1:0] var_q;
  logic             val_q;

  trail_entry       trail_din;
  trail_entry       trail_top;
  logic             trail_push;
  logic             trail_pop;
  logic             trail_set;

  // Level is the trail occupancy; both move together on PUSH and DISCARD.
  dpll_backtrack_ctrl_decision_trail #(
    .DEPTH (DEPTH)
  ) u_trail (
    .clock       (clock),
    .reset       (reset),
    .push        (trail_push),
    .pop         (trail_pop),
    .set_flipped (trail_set),
    .din         (trail_din),
    .top         (trail_top),
    .count       (level)
  );

  assign trail_din = '{var_id: TRAIL_VAR_W'(var_q), val: val_q, flipped: 1'b0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      formula_q <= zero_formula;
      var_q     <= '0;
      val_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && !conflict && decide) begin
        formula_q <= cur_formula;
        var_q     <= dec_var;
        val_q     <= dec_val;
      end else if (state == WAIT) begin
        // Hold the popped checkpoint so RESTORE does not depend on how
        // long the stack keeps stk_dout stable.
        formula_q <= stk.stk_dout;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    stk.stk_wr_en   = 1'b0;
    stk.stk_pop     = 1'b0;
    stk.stk_din     = zero_formula;
    restore_valid   = 1'b0;
    restore_formula = zero_formula;
    flip_var        = '0;
    flip_val        = 1'b0;
    trail_push      = 1'b0;
    trail_pop       = 1'b0;
    trail_set       = 1'b0;
    ready           = 1'b0;
    unsat           = 1'b0;
    error           = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (conflict) begin
          state_nxt = BT_CHECK;
        end else if (decide) begin
          if (stk.stk_full || level == LVL_W'(DEPTH)) begin
            state_nxt = ERR;
          end else begin
            state_nxt = PUSH;
          end
        end
      end

      PUSH: begin
        stk.stk_wr_en = 1'b1;
        stk.stk_din   = formula_q;
        trail_push    = 1'b1;
        state_nxt     = IDLE;
      end

      BT_CHECK: begin
        state_nxt = (level == '0) ? DONE_UNSAT : POP;
      end

      POP: begin
        stk.stk_pop = 1'b1;
        state_nxt   = stk.stk_empty ? ERR : WAIT;
      end

      WAIT: begin
        state_nxt = trail_top.flipped ? DISCARD : RESTORE;
      end

      RESTORE: begin
        restore_valid   = 1'b1;
        restore_formula = formula_q;
        flip_var        = VAR_W'(trail_top.var_id);
        flip_val        = ~trail_top.val;
        // The level stays open with its other branch, so its checkpoint
        // goes straight back onto the stack.
        stk.stk_wr_en   = 1'b1;
        stk.stk_din     = formula_q;
        trail_set       = 1'b1;
        state_nxt       = IDLE;
      end

      DISCARD: begin
        trail_pop = 1'b1;
        state_nxt = BT_CHECK;
      end

      DONE_UNSAT: begin
        unsat = 1'b1;
      end

      ERR: begin
        error = 1'b1;
      end

      default: begin
        state_nxt = ERR;
      end
    endcase
  end

endmodule
